store_buffer: RTL
=================

# store_buffer

Posted-write buffer between the pipelined core's memory stage and the data memory. It accepts full-word stores in a single cycle, queues them, and drains them into the data memory in program order when the memory port is not needed for a load. Loads that hit a pending store are forwarded from the buffer so the core always sees the youngest value. The core stalls only when a store finds the buffer full, or when a fence is issued while stores are still pending.

## Interface
- DEPTH, 4, number of entries; power of two, ≥2
- AW, 32, address width
- DW, 32, data width

- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- MemWrite  in  1  core store request, memory stage
- MemRead  in  1  core load request, memory stage
- Fence  in  1  core requests that all pending stores complete
- DataAdr  in  AW  core byte address; bits [1:0] ignored
- WriteData  in  DW  core store data
- ReadData  out  DW  load result to core; combinational
- Stall  out  1  core must hold its memory stage this cycle
- Empty  out  1  no pending stores
- dmem_we  out  1  write strobe to data memory
- dmem_adr  out  AW  data memory address
- dmem_wd  out  DW  data memory write data
- dmem_rd  in  DW  data memory read data; combinational in dmem_adr
- dmem_ready  in  1  data memory accepts the write on this edge

## Operation
- Storage is a circular FIFO: DEPTH entries of {word address AW-2 bits, data DW}, with head/tail pointers of log2(DEPTH) bits that wrap, and a count of $clog2(DEPTH+1) bits.
- Push: MemWrite=1 and count<DEPTH. The entry is written at the tail on the edge, and the tail increments modulo DEPTH.
- Full store: MemWrite=1 and count==DEPTH. Stall=1 and no push occurs. The core retries on later cycles with unchanged inputs.
- Fence: Fence=1 and count≠0 gives Stall=1. Fence=1 with count==0 gives no stall.
- Stall = (MemWrite & count==DEPTH) | (Fence & count≠0).
- Port arbitration, in priority order:
  - When MemRead=1, the load owns the port: dmem_adr=DataAdr, dmem_we=0, and no drain happens this cycle.
  - Otherwise, when count≠0: dmem_we=1, and dmem_adr/dmem_wd come from the head entry.
  - Otherwise: dmem_we=0, and dmem_adr/dmem_wd hold the head slot contents (don't-care).
- Pop: dmem_we=1 and dmem_ready=1 at the edge. The head increments modulo DEPTH.
- Simultaneous push and pop:
  - Both happen; count is unchanged.
  - Push is allowed even when count==DEPTH? No. Stall is evaluated on the pre-edge count, so a full buffer stalls even if a pop occurs on the same edge.
- Load forwarding:
  - When MemRead=1, DataAdr[AW-1:2] is compared with every valid entry.
  - On a hit, ReadData is the data of the youngest matching entry (nearest to tail).
  - On a miss, ReadData = dmem_rd.
- MemRead and MemWrite both high is illegal: the core never issues both. The bench never drives it, and behaviour is unspecified.
- Reset low: count, head and tail clear to 0, and all pending stores are discarded, including mid-drain. Entry storage need not be cleared.

## Timing
- Reset values:
  - Stall=0 (when MemWrite=0 and Fence=0).
  - Empty=1, dmem_we=0.
  - ReadData follows dmem_rd when MemRead=1.
- Stall, ReadData, dmem_we, dmem_adr and dmem_wd are combinational from inputs and registered state. There are no added cycles.
- Store latency: a store pushed at edge N is presented to dmem at the earliest in cycle N+1. It is written at edge N+1 if dmem_ready=1 and MemRead=0.
- Forwarding is valid in the cycle after the push edge. A store in the same cycle as a load cannot occur.
- Throughput: one push and one pop per cycle.
- Empty = (count==0). It is registered state, updated on the edge.

## Test plan
- **Reset, single store.** Release reset, then store adr 0x10 / data 0xDEADBEEF with dmem_ready=1 → dmem_we=1 at adr 0x10 next cycle, write data 0xDEADBEEF; Empty=1 one edge later.
- **Fill and stall.** Hold dmem_ready=0 and push 4 stores (0x0,0x4,0x8,0xC) → Empty=0. A fifth store gives Stall=1 and count stays 4. Raise dmem_ready → next edge pops 0x0, the fifth store is accepted on the following edge, and drain order is 0x0,0x4,0x8,0xC, then the fifth.
- **Forwarding.** dmem_ready=0; store 0x20←0x1, then 0x20←0x2; load 0x20 → ReadData=0x2. Load 0x24 → ReadData=dmem_rd.
- **Load priority.** Buffer holds one store; MemRead=1 for 3 cycles with dmem_ready=1 → dmem_we=0 throughout, count stays 1, and the store drains on the first cycle with MemRead=0.
- **Fence.** Two pending stores, Fence=1, dmem_ready=1 → Stall=1 for 2 cycles, then 0 once Empty=1.
- **Reset mid-drain.** Three pending stores; assert reset between edges → Empty=1 and dmem_we=0 immediately. After release, nothing is written.

Source files
------------

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer
// Description : Posted-write buffer between the core memory stage and the
//               data memory. Queues full-word stores in a circular FIFO,
//               drains them in program order whenever the memory port is not
//               claimed by a load, and forwards the youngest matching pending
//               store to loads.
// Revision    : 1.0 - initial release
// ============================================================================
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    // core side
    input  logic          i_mem_write,
    input  logic          i_mem_read,
    input  logic          i_fence,
    input  logic [AW-1:0] i_data_adr,
    input  logic [DW-1:0] i_write_data,
    output logic [DW-1:0] o_read_data,
    output logic          o_stall,
    output logic          o_empty,
    // data memory side
    output logic          o_dmem_we,
    output logic [AW-1:0] o_dmem_adr,
    output logic [DW-1:0] o_dmem_wd,
    input  logic [DW-1:0] i_dmem_rd,
    input  logic          i_dmem_ready
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] c_full_count = CW'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [AW-3:0] r_adr  [DEPTH];
    logic [DW-1:0] r_data [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          r_empty;

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    logic          w_full;
    logic          w_pending;
    logic          w_push;
    logic          w_drain;
    logic          w_pop;
    logic [CW-1:0] w_count_nxt;
    logic          w_hit;
    logic [DW-1:0] w_fwd_data;

    // Byte-offset bits of the core address never matter for word stores.
    logic w_unused_adr_lsb;
    assign w_unused_adr_lsb = &{1'b0, i_data_adr[1:0]};

    assign w_full    = (r_count == c_full_count);
    assign w_pending = (r_count != '0);

    // A store into a full buffer is refused even if a pop happens on the
    // same edge: the decision uses the pre-edge count only.
    assign w_push  = i_mem_write & ~w_full;

    // Loads own the memory port; draining only uses otherwise idle cycles.
    assign w_drain = ~i_mem_read & w_pending;
    assign w_pop   = w_drain & i_dmem_ready;

    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    assign o_stall = (i_mem_write & w_full) | (i_fence & w_pending);
    assign o_empty = r_empty;

    // ------------------------------------------------------------------
    // Memory port mux
    // ------------------------------------------------------------------
    assign o_dmem_we  = w_drain;
    assign o_dmem_adr = i_mem_read ? i_data_adr : {r_adr[r_head], 2'b00};
    assign o_dmem_wd  = r_data[r_head];

    // Forwarding: walk valid entries oldest to youngest so the last hit wins.
    always_comb begin
        logic [PW-1:0] w_idx;
        w_hit      = 1'b0;
        w_fwd_data = '0;
        w_idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PW'(i);
            if ((CW'(i) < r_count) && (r_adr[w_idx] == i_data_adr[AW-1:2])) begin
                w_hit      = 1'b1;
                w_fwd_data = r_data[w_idx];
            end
        end
    end

    assign o_read_data = (i_mem_read & w_hit) ? w_fwd_data : i_dmem_rd;

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Entry storage: written at the tail on a push, never cleared.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_adr[r_tail]  <= i_data_adr[AW-1:2];
            r_data[r_tail] <= i_write_data;
        end
    end

    // Pointers, occupancy and empty flag; reset discards all pending stores.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_empty <= 1'b1;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
        end
    end

endmodule
`default_nettype wire
